// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
//   Shared definitions for the multicycle controller and the ALU control
//   unit: FSM state codes, opcode/funct constants, 4-bit alu_op class codes,
//   datapath mux select codes and the registered instruction class.
package multicycle_control_pkg;

  // FSM state codes
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_BRANCH = 3'd5;
  localparam logic [2:0] ST_JUMP   = 3'd6;

  // IR[31:26] opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct that retires without writing the register file
  localparam logic [5:0] FUNCT_NOP = 6'b000010;

  // ALU-control class codes
  localparam logic [3:0] ALU_ADDI = 4'b0000;
  localparam logic [3:0] ALU_R    = 4'b0001;
  localparam logic [3:0] ALU_ORI  = 4'b0010;
  localparam logic [3:0] ALU_ANDI = 4'b0011;
  localparam logic [3:0] ALU_LW   = 4'b0100;
  localparam logic [3:0] ALU_SW   = 4'b0101;
  localparam logic [3:0] ALU_SLTI = 4'b0110;
  localparam logic [3:0] ALU_BEQ  = 4'b0111;
  localparam logic [3:0] ALU_BNE  = 4'b1000;
  localparam logic [3:0] ALU_BGTZ = 4'b1001;

  // alu_src_b selects
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  // pc_src selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // R-type no-op gets its own class so the FSM outputs depend only on
  // state plus the registered class, never on a live funct field.
  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_R,
    CLS_RNOP,
    CLS_ADDI,
    CLS_SLTI,
    CLS_ANDI,
    CLS_ORI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_BGTZ,
    CLS_J,
    CLS_ILLEGAL
  } instr_class_e;

  function automatic logic [3:0] class_alu_op(input instr_class_e c);
    logic [3:0] op;
    case (c)
      CLS_R, CLS_RNOP: op = ALU_R;
      CLS_ORI:         op = ALU_ORI;
      CLS_ANDI:        op = ALU_ANDI;
      CLS_LW:          op = ALU_LW;
      CLS_SW:          op = ALU_SW;
      CLS_SLTI:        op = ALU_SLTI;
      CLS_BEQ:         op = ALU_BEQ;
      CLS_BNE:         op = ALU_BNE;
      CLS_BGTZ:        op = ALU_BGTZ;
      default:         op = ALU_ADDI;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_control_opcode_decoder.sv
// opcode_decoder
//   Combinational opcode/funct to instruction-class decoder.
//   i_opcode : IR[31:26]
//   i_funct  : IR[5:0], only inspected for the R-type no-op
//   o_class  : decoded class, CLS_ILLEGAL for any unsupported opcode
module opcode_decoder
  import multicycle_control_pkg::*;
(
  input  logic [5:0]   i_opcode,
  input  logic [5:0]   i_funct,
  output instr_class_e o_class
);

  always_comb begin
    o_class = CLS_ILLEGAL;
    case (i_opcode)
      OP_RTYPE: o_class = (i_funct == FUNCT_NOP) ? CLS_RNOP : CLS_R;
      OP_J:     o_class = CLS_J;
      OP_BEQ:   o_class = CLS_BEQ;
      OP_BNE:   o_class = CLS_BNE;
      OP_BGTZ:  o_class = CLS_BGTZ;
      OP_ADDI:  o_class = CLS_ADDI;
      OP_SLTI:  o_class = CLS_SLTI;
      OP_ANDI:  o_class = CLS_ANDI;
      OP_ORI:   o_class = CLS_ORI;
      OP_LW:    o_class = CLS_LW;
      OP_SW:    o_class = CLS_SW;
      default:  o_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multicycle CPU control FSM with retired-instruction counter.
//   clk, rst_n             : clock, async active-low reset
//   opcode, funct          : IR fields (opcode valid from DECODE onward)
//   mem_ready              : memory completes the current access this cycle
//   branch_true            : ALU branch condition
//   pc_write .. iord       : datapath strobes and mux selects
//   alu_src_b, pc_src      : ALU B / PC source selects
//   alu_op                 : ALU-control class code
//   illegal                : one-cycle pulse on unsupported opcode (DECODE)
//   retired                : completed-instruction count, wraps at 2^32
//
//   state  | meaning
//   FETCH  | read IR from memory, PC+4; waits on mem_ready
//   DECODE | register instruction class, compute branch target
//   EXEC   | ALU operation for R-type / immediate / address
//   MEM    | data access for lw/sw; waits on mem_ready
//   WB     | register-file write
//   BRANCH | conditional PC update from ALUOut
//   JUMP   | PC <- jump target
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  input  logic        branch_true,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        iord,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [3:0]  alu_op,
  output logic        illegal,
  output logic [31:0] retired
);

  logic [2:0]   r_state;
  logic [2:0]   w_state_nxt;
  instr_class_e r_class;
  instr_class_e w_dec_class;
  logic [31:0]  r_retired;
  logic [31:0]  w_retired_next;
  logic         w_retire;

  opcode_decoder u_dec (
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_class  (w_dec_class)
  );

  always_comb begin
    w_state_nxt = ST_FETCH;
    case (r_state)
      ST_FETCH:  w_state_nxt = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (w_dec_class)
          CLS_BEQ, CLS_BNE, CLS_BGTZ: w_state_nxt = ST_BRANCH;
          CLS_J:                      w_state_nxt = ST_JUMP;
          CLS_ILLEGAL:                w_state_nxt = ST_FETCH;
          default:                    w_state_nxt = ST_EXEC;
        endcase
      end
      ST_EXEC:   w_state_nxt = (r_class == CLS_LW || r_class == CLS_SW) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (!mem_ready)             w_state_nxt = ST_MEM;
        else if (r_class == CLS_LW) w_state_nxt = ST_WB;
        else                        w_state_nxt = ST_FETCH;
      end
      default:   w_state_nxt = ST_FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  assign w_retire = (r_state == ST_WB) || (r_state == ST_BRANCH) || (r_state == ST_JUMP) ||
                    (r_state == ST_MEM && mem_ready && r_class == CLS_SW);

  assign w_retired_next = r_retired + {31'd0, w_retire};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_class   <= CLS_NONE;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_retired <= w_retired_next;
      if (r_state == ST_DECODE) r_class <= w_dec_class;
    end
  end

  assign retired = r_retired;

  // Outputs are gated by rst_n so every strobe drops the moment reset
  // asserts, even though the reset state itself is FETCH.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    iord       = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PCSRC_ALU;
    alu_op     = ALU_ADDI;
    illegal    = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        ST_DECODE: begin
          alu_src_b = SRCB_IMM_SL2;
          illegal   = (w_dec_class == CLS_ILLEGAL);
        end
        ST_EXEC: begin
          alu_src_b = (r_class == CLS_R || r_class == CLS_RNOP) ? SRCB_REG : SRCB_IMM;
          alu_op    = class_alu_op(r_class);
        end
        ST_MEM: begin
          iord      = 1'b1;
          mem_read  = (r_class == CLS_LW);
          mem_write = (r_class == CLS_SW);
        end
        ST_WB: begin
          reg_write  = (r_class != CLS_RNOP);
          reg_dst    = (r_class == CLS_R || r_class == CLS_RNOP);
          mem_to_reg = (r_class == CLS_LW);
        end
        ST_BRANCH: begin
          alu_src_b = SRCB_REG;
          pc_src    = PCSRC_ALUOUT;
          pc_write  = branch_true;
          alu_op    = class_alu_op(r_class);
        end
        ST_JUMP: begin
          pc_src   = PCSRC_JUMP;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        mem_ready, branch_true;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, iord;
  logic [1:0]  alu_src_b, pc_src;
  logic [3:0]  alu_op;
  logic        illegal;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .branch_true(branch_true),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .iord(iord),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op), .illegal(illegal),
    .retired(retired)
  );

  // Expected per-instruction totals (cycles, retired delta, OR of alu_op and
  // pc_src over the instruction, and cycle counts of each strobe).
  typedef struct {
    int cyc; int ret; logic [3:0] alu; logic [1:0] pcs;
    int irw; int pcw; int rw; int rd; int m2r; int mr; int mwr; int ill;
  } exp_t;

  typedef struct {
    int irw; int pcw; int rw; int rd; int m2r; int mr; int mwr; int ill; int both;
    logic [3:0] alu; logic [1:0] pcs; logic [31:0] ret_end; bit end_fetch;
  } obs_t;

  typedef struct {
    logic [5:0] op; logic [5:0] fn; bit bt; int fw; int mw; exp_t e;
  } vec_t;

  logic [1:0] sb_q[$];
  bit         rw_q[$];
  vec_t       vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mke(int cyc, int ret, logic [3:0] alu, logic [1:0] pcs,
                               int irw, int pcw, int rw, int rd, int m2r, int mr, int mwr, int ill);
    exp_t e;
    e.cyc = cyc; e.ret = ret; e.alu = alu; e.pcs = pcs; e.irw = irw; e.pcw = pcw;
    e.rw = rw; e.rd = rd; e.m2r = m2r; e.mr = mr; e.mwr = mwr; e.ill = ill;
    return e;
  endfunction

  function automatic vec_t mkv(logic [5:0] op, logic [5:0] fn, bit bt, int fw, int mw, exp_t e);
    vec_t v;
    v.op = op; v.fn = fn; v.bt = bt; v.fw = fw; v.mw = mw; v.e = e;
    return v;
  endfunction

  // Reference model: instruction-level totals from the opcode table and
  // cycle-count rules, with fw/mw wait cycles in FETCH and MEM.
  function automatic exp_t model(logic [5:0] op, logic [5:0] fn, bit bt, int fw, int mw);
    exp_t e;
    e = mke(fw + 4, 1, 4'h0, 2'b00, 1, 1, 1, 0, 0, fw + 1, 0, 0);
    case (op)
      6'b000000: begin e.alu = 4'h1; e.rd = 1; e.rw = (fn == 6'b000010) ? 0 : 1; end
      6'b001000: e.alu = 4'h0;
      6'b001101: e.alu = 4'h2;
      6'b001100: e.alu = 4'h3;
      6'b001010: e.alu = 4'h6;
      6'b100011: begin e.cyc = fw + mw + 5; e.alu = 4'h4; e.m2r = 1; e.mr += mw + 1; end
      6'b101011: begin e.cyc = fw + mw + 4; e.alu = 4'h5; e.rw = 0; e.mwr = mw + 1; end
      6'b000100, 6'b000101, 6'b000111: begin
        e.cyc = fw + 3; e.rw = 0; e.pcs = 2'b01; e.pcw += int'(bt);
        e.alu = (op == 6'b000100) ? 4'h7 : (op == 6'b000101) ? 4'h8 : 4'h9;
      end
      6'b000010: begin e.cyc = fw + 3; e.rw = 0; e.pcs = 2'b10; e.pcw = 2; end
      default:   begin e.cyc = fw + 2; e.ret = 0; e.rw = 0; e.ill = 1; end
    endcase
    return e;
  endfunction

  // Drives one instruction for ncyc cycles, acting as a memory that answers
  // a fetch after fw wait cycles and a data access after mw wait cycles.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit bt,
                           input int fw, input int mw, input int ncyc, output obs_t o);
    int fl = fw;
    int ml = mw;
    o.irw = 0; o.pcw = 0; o.rw = 0; o.rd = 0; o.m2r = 0; o.mr = 0; o.mwr = 0;
    o.ill = 0; o.both = 0; o.alu = '0; o.pcs = '0; o.ret_end = '0; o.end_fetch = 1'b0;
    sb_q.delete();
    rw_q.delete();
    opcode = op; funct = fn; branch_true = bt;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (!iord) begin mem_ready = (fl == 0); if (fl > 0) fl--; end
        else       begin mem_ready = (ml == 0); if (ml > 0) ml--; end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      o.irw += int'(ir_write);   o.pcw += int'(pc_write);  o.rw  += int'(reg_write);
      o.rd  += int'(reg_dst);    o.m2r += int'(mem_to_reg); o.mr += int'(mem_read);
      o.mwr += int'(mem_write);  o.ill += int'(illegal);
      o.both += int'(mem_read & mem_write);
      o.alu |= alu_op;
      o.pcs |= pc_src;
      sb_q.push_back(alu_src_b);
      rw_q.push_back(reg_write);
    end
    @(posedge clk);
    #1;
    o.ret_end   = retired;
    o.end_fetch = mem_read && !iord && !mem_write && (alu_src_b == 2'b01);
  endtask

  task automatic check_instr(input string tag, input exp_t e, input obs_t o, input logic [31:0] ret0);
    chk({tag, ".retired_delta"}, o.ret_end - ret0, e.ret);
    chk({tag, ".alu_op"},     32'(o.alu), 32'(e.alu));
    chk({tag, ".pc_src"},     32'(o.pcs), 32'(e.pcs));
    chk({tag, ".ir_write"},   o.irw, e.irw);
    chk({tag, ".pc_write"},   o.pcw, e.pcw);
    chk({tag, ".reg_write"},  o.rw,  e.rw);
    chk({tag, ".reg_dst"},    o.rd,  e.rd);
    chk({tag, ".mem_to_reg"}, o.m2r, e.m2r);
    chk({tag, ".mem_read"},   o.mr,  e.mr);
    chk({tag, ".mem_write"},  o.mwr, e.mwr);
    chk({tag, ".illegal"},    o.ill, e.ill);
    chk({tag, ".rd_wr_overlap"}, o.both, 0);
    chk({tag, ".back_in_fetch"}, 32'(o.end_fetch), 1);
  endtask

  logic [5:0] oplist[13] = '{6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b000111,
                             6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b100011,
                             6'b101011, 6'b111111, 6'b010000};

  initial begin
    obs_t o;
    exp_t e;
    logic [31:0] ret0;

    // Hand-computed expectations: mke(cyc,ret,alu,pcs,irw,pcw,rw,rd,m2r,mr,mwr,ill)
    vecs.push_back(mkv(6'b000000, 6'b100000, 0, 0, 0, mke(4, 1, 4'h1, 2'b00, 1, 1, 1, 1, 0, 1, 0, 0)));
    vecs.push_back(mkv(6'b000000, 6'b000010, 0, 0, 0, mke(4, 1, 4'h1, 2'b00, 1, 1, 0, 1, 0, 1, 0, 0)));
    vecs.push_back(mkv(6'b001101, 6'b000000, 0, 1, 0, mke(5, 1, 4'h2, 2'b00, 1, 1, 1, 0, 0, 2, 0, 0)));
    vecs.push_back(mkv(6'b001100, 6'b000000, 0, 0, 0, mke(4, 1, 4'h3, 2'b00, 1, 1, 1, 0, 0, 1, 0, 0)));
    vecs.push_back(mkv(6'b001010, 6'b000000, 0, 0, 0, mke(4, 1, 4'h6, 2'b00, 1, 1, 1, 0, 0, 1, 0, 0)));
    vecs.push_back(mkv(6'b100011, 6'b000000, 0, 0, 3, mke(8, 1, 4'h4, 2'b00, 1, 1, 1, 0, 1, 5, 0, 0)));
    vecs.push_back(mkv(6'b101011, 6'b000000, 0, 2, 1, mke(7, 1, 4'h5, 2'b00, 1, 1, 0, 0, 0, 3, 2, 0)));
    vecs.push_back(mkv(6'b000100, 6'b000000, 1, 0, 0, mke(3, 1, 4'h7, 2'b01, 1, 2, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mkv(6'b000101, 6'b000000, 0, 0, 0, mke(3, 1, 4'h8, 2'b01, 1, 1, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mkv(6'b000111, 6'b000000, 1, 1, 0, mke(4, 1, 4'h9, 2'b01, 1, 2, 0, 0, 0, 2, 0, 0)));
    vecs.push_back(mkv(6'b000010, 6'b000000, 0, 0, 0, mke(3, 1, 4'h0, 2'b10, 1, 2, 0, 0, 0, 1, 0, 0)));
    vecs.push_back(mkv(6'b111111, 6'b000000, 0, 0, 0, mke(2, 0, 4'h0, 2'b00, 1, 1, 0, 0, 0, 1, 0, 1)));
    vecs.push_back(mkv(6'b000011, 6'b000000, 0, 0, 0, mke(2, 0, 4'h0, 2'b00, 1, 1, 0, 0, 0, 1, 0, 1)));
    vecs.push_back(mkv(6'b100011, 6'b000000, 0, 1, 0, mke(6, 1, 4'h4, 2'b00, 1, 1, 1, 0, 1, 3, 0, 0)));

    rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0; branch_true = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.strobes", 32'({pc_write, ir_write, mem_read, mem_write, reg_write,
                              reg_dst, mem_to_reg, iord, illegal}), 0);
    chk("reset.alu_op", 32'(alu_op), 0);
    chk("reset.retired", retired, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset.release_fetch", 32'(mem_read && !iord), 1);

    // addi straight after reset, zero-wait memory
    run_instr(6'b001000, 6'b000000, 0, 0, 0, 4, o);
    check_instr("addi_first", mke(4, 1, 4'h0, 2'b00, 1, 1, 1, 0, 0, 1, 0, 0), o, 32'd0);
    chk("addi_first.srcb_fetch",  32'(sb_q[0]), 32'(2'b01));
    chk("addi_first.srcb_decode", 32'(sb_q[1]), 32'(2'b11));
    chk("addi_first.srcb_exec",   32'(sb_q[2]), 32'(2'b10));
    chk("addi_first.rw_in_wb",    32'(rw_q[3]), 1);
    chk("addi_first.retired",     o.ret_end, 1);

    foreach (vecs[i]) begin
      ret0 = retired;
      run_instr(vecs[i].op, vecs[i].fn, vecs[i].bt, vecs[i].fw, vecs[i].mw, vecs[i].e.cyc, o);
      check_instr($sformatf("vec%0d", i), vecs[i].e, o, ret0);
    end

    // Reset while sw waits in MEM
    run_instr(6'b101011, 6'b000000, 0, 0, 5, 4, o);
    chk("rst_mid.mem_write_before", 32'(mem_write), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.mem_write_drop", 32'(mem_write), 0);
    chk("rst_mid.mem_read_drop", 32'(mem_read), 0);
    chk("rst_mid.retired", retired, 0);
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_mid.release_fetch", 32'(mem_read && !iord && !mem_write), 1);
    run_instr(6'b001000, 6'b000000, 0, 0, 0, 4, o);
    check_instr("rst_mid.addi", model(6'b001000, 6'b000000, 0, 0, 0), o, 32'd0);

    // Counter wrap: preload while stalled in FETCH, then retire a jump
    mem_ready = 1'b0;
    @(negedge clk);
    force dut.w_retired_next = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.w_retired_next;
    chk("wrap.preload", retired, 32'hFFFF_FFFF);
    run_instr(6'b000010, 6'b000000, 0, 0, 0, 3, o);
    check_instr("wrap.j", model(6'b000010, 6'b000000, 0, 0, 0), o, 32'hFFFF_FFFF);
    chk("wrap.retired_zero", o.ret_end, 0);

    // Randomized instruction stream against the model
    for (int i = 0; i < 150; i++) begin
      logic [5:0] op, fn;
      bit bt;
      int fw, mw;
      op = oplist[$urandom_range(0, 12)];
      fn = ($urandom_range(0, 3) == 0) ? 6'b000010 : 6'($urandom);
      bt = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      e = model(op, fn, bt, fw, mw);
      ret0 = retired;
      run_instr(op, fn, bt, fw, mw, e.cyc, o);
      check_instr($sformatf("rnd%0d_op%06b", i, op), e, o, ret0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port opcode, input, 6 bits: IR[31:26], valid from DECODE onward.
REQ-004 SHALL have port funct, input, 6 bits: IR[5:0], used only to detect R-type funct 000010 (no-op).
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completes the current access this cycle.
REQ-006 SHALL have port branch_true, input, 1 bit: ALU branch condition for the current alu_op.
REQ-007 SHALL have outputs pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, iord, each 1 bit: datapath strobes and mux selects.
REQ-008 SHALL have output alu_src_b, 2 bits: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
REQ-009 SHALL have output pc_src, 2 bits: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-010 SHALL have output alu_op, 4 bits: ALU-control class code.
REQ-011 SHALL have output illegal, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-012 SHALL have output retired, 32 bits: count of completed instructions.

Function
REQ-013 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP; all outputs are decoded from state plus a registered instruction class only.
REQ-014 FETCH SHALL assert mem_read, iord=0, alu_src_b=01, alu_op=0000, pc_src=00; it SHALL hold until mem_ready=1, and in that cycle SHALL pulse ir_write and pc_write and go to DECODE.
REQ-015 DECODE SHALL register the instruction class from opcode, drive alu_src_b=11, alu_op=0000, and transition: R-type/addi/ori/andi/slti/lw/sw -> EXEC; beq/bne/bgtz -> BRANCH; j (000010) -> JUMP; any other opcode -> FETCH with illegal=1 for that cycle.
REQ-016 Opcode map: R 000000, j 000010, beq 000100, bne 000101, bgtz 000111, addi 001000, slti 001010, andi 001100, ori 001101, lw 100011, sw 101011.
REQ-017 alu_op in EXEC/BRANCH SHALL be: addi 0000, R 0001, ori 0010, andi 0011, lw 0100, sw 0101, slti 0110, beq 0111, bne 1000, bgtz 1001; all other states drive 0000.
REQ-018 EXEC SHALL drive alu_src_b=00 for R-type and 10 otherwise; next state is MEM for lw/sw and WB otherwise.
REQ-019 MEM SHALL assert iord=1 and mem_read (lw) or mem_write (sw), holding until mem_ready=1; then lw -> WB, sw -> FETCH.
REQ-020 WB SHALL pulse reg_write for one cycle, with reg_dst=1 for R-type, mem_to_reg=1 for lw, then go to FETCH; an R-type with funct 000010 SHALL suppress reg_write.
REQ-021 BRANCH SHALL drive alu_src_b=00, pc_src=01, pc_write=branch_true, then go to FETCH (1 cycle, taken or not).
REQ-022 JUMP SHALL drive pc_src=10, pc_write=1, then go to FETCH.
REQ-023 retired SHALL increment by 1 on exit from WB, on MEM->FETCH for sw, and on exit from BRANCH or JUMP; it SHALL wrap from 0xFFFFFFFF to 0 and not count illegal opcodes.
REQ-024 Cycle counts with zero-wait memory SHALL be: R/imm 4, lw 5, sw 4, branch 3, jump 3.
REQ-025 mem_read and mem_write SHALL never be asserted together; outputs not named for a state SHALL be 0.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state FETCH, instruction class cleared, retired=0, all strobes 0, alu_op=0000.
REQ-027 Reset asserted mid-instruction (including mid-MEM wait) SHALL abort it without a retired increment; the first cycle after release is FETCH.

Structure
REQ-028 A shared package SHALL hold the state enumeration, opcode constants and the 4-bit alu_op class constants, shared with the ALU control unit.
REQ-029 The opcode-to-class decoder SHALL be a separate combinational sub-module, opcode_decoder.

Verification
REQ-030 addi after reset, mem_ready=1 -> FETCH,DECODE,EXEC(alu_op=0000,alu_src_b=10),WB(reg_write=1); retired=1 after 4 cycles.
REQ-031 lw with mem_ready low 3 cycles in MEM -> mem_read/iord held 4 cycles, alu_op=0100 in EXEC, WB with mem_to_reg=1; 8 cycles total.
REQ-032 bne with branch_true=0, then bgtz with branch_true=1 -> alu_op 1000 then 1001 in BRANCH; pc_write 0 then 1; retired +2.
REQ-033 opcode 111111 -> illegal pulses in DECODE, next state FETCH, retired unchanged.
REQ-034 rst_n low during MEM of sw -> mem_write drops immediately, retired=0, FETCH after release.
REQ-035 Preload retired to 0xFFFFFFFF via j -> retired wraps to 0.
